skein_nonce_scanner: RTL
========================

# skein_nonce_scanner

Drives the pipelined `skein512` core with a nonce search and consumes its hash output. The scanner latches one work unit (midstate, 96-bit data tail, nonce range, target) and issues one nonce per clock into the core. It tracks each nonce through the core's fixed pipeline latency and compares every emerging hash against the target. Winning nonces are queued in a small FIFO for the host.

## Interface
- `LATENCY`, 20: `skein512` pipeline depth, in cycles from `nonce` in to `hash` out; must be ≥1.
- `FIFO_DEPTH`, 4: found-nonce queue depth; power of two.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a scan; sampled only in IDLE.
- `abort`  in  1  stop issuing nonces; sampled only in SCAN.
- `midstate_in`  in  512  work midstate, latched on start.
- `data_in`  in  96  work data tail, latched on start.
- `nonce_first`  in  32  first nonce, inclusive; latched on start.
- `nonce_last`  in  32  last nonce, inclusive; latched on start.
- `target`  in  64  hit when `core_hash[511:448]` ≤ `target` (unsigned); latched on start.
- `core_midstate`  out  512  to `skein512.midstate`.
- `core_data`  out  96  to `skein512.data`.
- `core_nonce`  out  32  to `skein512.nonce`.
- `core_hash`  in  512  from `skein512.hash`.
- `busy`  out  1  high in SCAN and DRAIN.
- `done`  out  1  one-cycle pulse at scan completion.
- `found_valid`  out  1  FIFO non-empty.
- `found_nonce`  out  32  FIFO head.
- `found_ready`  in  1  pop the head when `found_valid` is also high.
- `found_ovf`  out  1  sticky; a hit was dropped because the FIFO was full. Cleared on accepted start.

## Operation
- States: IDLE, SCAN, DRAIN.
  - IDLE → SCAN on `start`. Latch all work inputs, set `issue_nonce = nonce_first`, clear `found_ovf`. The FIFO is not flushed.
  - SCAN: each cycle drive `core_nonce = issue_nonce` and shift a 1 into the LATENCY-bit valid shift register. Then:
    - If `issue_nonce == nonce_last` or `abort`, go to DRAIN.
    - Otherwise increment `issue_nonce` mod 2^32.
  - On abort, the nonce driven in that cycle is still issued.
  - Outside SCAN, a 0 is shifted into the valid shift register and `core_nonce` holds its last value.
  - DRAIN: when the valid shift register is all zero, pulse `done` and go to IDLE.
- Range wraps: `nonce_last < nonce_first` scans through 0xFFFFFFFF to 0. `nonce_first == nonce_last` scans exactly one nonce.
- Result tagging:
  - The `out_nonce` counter loads `nonce_first` on start.
  - It increments on every cycle the valid shift register output is 1.
  - `core_hash` seen while that bit is 1 belongs to `out_nonce`.
- Hit: valid output and `core_hash[511:448] ≤ target` → push `out_nonce`. Hits are queued in issue order.
- FIFO:
  - Push on a full FIFO without a same-cycle pop → hit dropped, `found_ovf` set.
  - Simultaneous push and pop on a full FIFO → both succeed, no overflow.
  - Push on empty with a same-cycle pop is not possible; `found_valid` is registered.
- `start` is ignored while busy. `abort` is ignored outside SCAN.
- Reset:
  - All outputs are 0: `core_*` = 0, `busy`, `done`, `found_valid`, `found_nonce`, `found_ovf`.
  - Valid shift register and FIFO cleared; state = IDLE.
  - Reset mid-scan discards all in-flight results.

## Timing
- `start` sampled at edge T. Then:
  - `core_nonce = nonce_first` is valid from T+1.
  - Its hash appears on `core_hash` in cycle T+1+LATENCY.
  - A hit pushes at the end of that cycle, so `found_valid` rises at T+2+LATENCY.
- Throughput: one nonce per cycle, with no bubbles in SCAN.
- With N nonces issued, `done` pulses at cycle T+N+LATENCY+1 relative to start and `busy` falls in the same cycle. `busy` rises at T+1.
- The hash compare is registered exactly once, so the result-path latency is 1 cycle after `core_hash`.

## Test plan
The bench uses a behavioural core stub with LATENCY=4 and `hash = {32'd0, nonce, 448'd0}` delayed 4 cycles.

- **Single hit:** nonce 10..20, target 64'd12 → hits 10, 11, 12 in order. With `found_ready` held low until done, `found_ovf` = 0 and there are 3 entries. `done` arrives 11+4+1 cycles after start.
- **Overflow:** nonce 0..9, target 64'd7, `found_ready` = 0 → FIFO holds 0, 1, 2, 3 and `found_ovf` = 1. Popping yields exactly 0, 1, 2, 3.
- **Wrap:** nonce 0xFFFFFFFE..0x00000001, target 64'hFFFFFFFF → 4 hits in order FFFFFFFE, FFFFFFFF, 0, 1.
- **Abort:**
  - Setup: nonce 100..1000, target 64'd102, abort asserted on the 3rd SCAN cycle (nonce 102 issued).
  - Expect hits 100, 101, 102 and nothing more.
  - Expect `done` 4+1 cycles after abort.
- **Start while busy / concurrent pop-push:**
  - A second `start` mid-scan is ignored and the latched range is unchanged.
  - With the FIFO full and `found_ready` = 1 during a hit, there is no overflow.
- **Reset mid-scan:**
  - Assert `rst` during DRAIN.
  - Expect all outputs 0 next cycle, no `done`, and no `found_valid` afterward.
  - A subsequent scan then behaves normally.

Source files
------------

// File: rtl/skein_nonce_scanner.sv
// Nonce-search sequencer for a pipelined skein512 core: issues nonces, filters hashes, queues hits.
// Latency: first nonce on core_nonce 1 cycle after start; a hit shows on found_* 1 cycle after its hash.
// Backpressure: none toward the core (one nonce per cycle); a full found FIFO drops hits and sets found_ovf.
module skein_nonce_scanner #(
  parameter int LATENCY    = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [511:0] midstate_in,
  input  logic [95:0]  data_in,
  input  logic [31:0]  nonce_first,
  input  logic [31:0]  nonce_last,
  input  logic [63:0]  target,
  output logic [511:0] core_midstate,
  output logic [95:0]  core_data,
  output logic [31:0]  core_nonce,
  input  logic [511:0] core_hash,
  output logic         busy,
  output logic         done,
  output logic         found_valid,
  output logic [31:0]  found_nonce,
  input  logic         found_ready,
  output logic         found_ovf
);

  // Pointer width; FIFO_DEPTH is a power of two and at least 2.
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [511:0]       midstate_q, midstate_d;
  logic [95:0]        data_q, data_d;
  logic [31:0]        issue_nonce_q, issue_nonce_d;
  logic [31:0]        nonce_last_q, nonce_last_d;
  logic [63:0]        target_q, target_d;
  logic [31:0]        out_nonce_q, out_nonce_d;
  logic [LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;

  logic [31:0]        fifo_mem_q [FIFO_DEPTH];
  logic [31:0]        fifo_mem_d [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;

  logic               scan_bit;
  logic               start_acc;
  logic               res_vld;
  logic               hit;
  logic               fifo_full;
  logic               fifo_push;
  logic               fifo_pop;
  logic               unused_hash_lo;

  // Only the top 64 hash bits take part in the target compare.
  assign unused_hash_lo = ^core_hash[447:0];

  // The oldest slot of the valid shift register marks the hash currently on core_hash.
  assign res_vld   = vld_sr_q[LATENCY-1];
  assign hit       = res_vld && (core_hash[511:448] <= target_q);
  assign fifo_full = (count_q == FULL_CNT);

  assign core_midstate = midstate_q;
  assign core_data     = data_q;
  assign core_nonce    = issue_nonce_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign found_valid   = (count_q != '0);
  assign found_nonce   = fifo_mem_q[rd_ptr_q];
  assign found_ovf     = ovf_q;

  // Next state, work latch, nonce issue counter and result tagging counter.
  always_comb begin
    state_d       = state_q;
    midstate_d    = midstate_q;
    data_d        = data_q;
    issue_nonce_d = issue_nonce_q;
    nonce_last_d  = nonce_last_q;
    target_d      = target_q;
    out_nonce_d   = out_nonce_q;
    done_d        = 1'b0;
    scan_bit      = 1'b0;
    start_acc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          start_acc     = 1'b1;
          midstate_d    = midstate_in;
          data_d        = data_in;
          issue_nonce_d = nonce_first;
          nonce_last_d  = nonce_last;
          target_d      = target;
          state_d       = SCAN;
        end
      end
      SCAN: begin
        scan_bit = 1'b1;
        // The nonce on core_nonce this cycle is issued even when aborting.
        if ((issue_nonce_q == nonce_last_q) || abort) begin
          state_d = DRAIN;
        end else begin
          issue_nonce_d = issue_nonce_q + 32'd1;
        end
      end
      DRAIN: begin
      end
      default: state_d = IDLE;
    endcase
    vld_sr_d = LATENCY'({vld_sr_q, scan_bit});
    // Finish on the edge that retires the last in-flight result, so done and busy-fall coincide.
    if ((state_q == DRAIN) && (vld_sr_d == '0)) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
    if (start_acc) begin
      out_nonce_d = nonce_first;
    end else if (res_vld) begin
      out_nonce_d = out_nonce_q + 32'd1;
    end
  end

  // Found-nonce FIFO; a pop frees a slot for a same-cycle push even when full.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = start_acc ? 1'b0 : ovf_q;
    fifo_pop   = found_ready && (count_q != '0);
    fifo_push  = hit && (!fifo_full || fifo_pop);
    if (hit && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end
    if (fifo_push) begin
      fifo_mem_d[wr_ptr_q] = out_nonce_q;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({fifo_push, fifo_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Work registers, issue/tag counters and the in-flight valid shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      midstate_q    <= '0;
      data_q        <= '0;
      issue_nonce_q <= '0;
      nonce_last_q  <= '0;
      target_q      <= '0;
      out_nonce_q   <= '0;
      vld_sr_q      <= '0;
      done_q        <= 1'b0;
    end else begin
      midstate_q    <= midstate_d;
      data_q        <= data_d;
      issue_nonce_q <= issue_nonce_d;
      nonce_last_q  <= nonce_last_d;
      target_q      <= target_d;
      out_nonce_q   <= out_nonce_d;
      vld_sr_q      <= vld_sr_d;
      done_q        <= done_d;
    end
  end

  // FIFO storage, pointers and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule
